// File: rtl/load_seq_pkg.sv
// Shared types for the load sequencer.
// Request entries and FSM state encoding.
package load_seq_pkg;

  localparam int LSEQ_WIDTH = 4;
  localparam int LSEQ_DEPTH = 4;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LOAD  = 2'd1,
    GUARD = 2'd2
  } lseq_state_e;

  typedef struct packed {
    logic                  imm;
    logic [LSEQ_WIDTH-1:0] data;
  } lseq_entry_t;

  // Head entry may fire now: immediate, or q sits at terminal count.
  function automatic logic lseq_trig(
    input lseq_entry_t           e,
    input logic [LSEQ_WIDTH-1:0] q,
    input logic [LSEQ_WIDTH-1:0] tc
  );
    return e.imm || (q == tc);
  endfunction

endpackage

// File: rtl/load_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO for queued reload entries.
// flush clears everything and wins over push/pop.
module sync_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == C_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case (1'b1)
        (do_push && !do_pop): count <= count + C_ONE;
        (do_pop && !do_push): count <= count - C_ONE;
        default:              count <= count;
      endcase
    end
  end

  // Storage needs no reset; reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/load_sequencer.sv
// Feeds queued reload values to a loadable counter.
// Fires each entry immediately or on terminal count.
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int              WIDTH = LSEQ_WIDTH,
  parameter int              DEPTH = LSEQ_DEPTH,
  parameter logic [WIDTH-1:0] TC   = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [WIDTH-1:0]       req_data,
  input  logic                   req_imm,
  output logic                   req_ready,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       q,
  output logic                   load,
  output logic [WIDTH-1:0]       data,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int EW = $bits(lseq_entry_t);

  lseq_state_e state;
  lseq_state_e state_nx;

  lseq_entry_t din;
  lseq_entry_t head;
  logic        push;
  logic        pop;
  logic        fire;
  logic        full;
  logic        empty;

  assign req_ready = rst && !full && !flush;
  assign push      = req_valid && req_ready;
  assign din       = '{imm: req_imm, data: LSEQ_WIDTH'(req_data)};

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (pending),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_nx;
  end

  // Next state: one-cycle LOAD, then one GUARD cycle for q to settle.
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT:    if (fire) state_nx = LOAD;
      LOAD:    state_nx = GUARD;
      GUARD:   state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // Fire decision; popping the head is the same event.
  always_comb begin
    fire = 1'b0;
    pop  = 1'b0;
    if (state == WAIT && !empty) begin
      fire = lseq_trig(head, LSEQ_WIDTH'(q), LSEQ_WIDTH'(TC));
    end
    pop = fire;
  end

  // Counter-facing pins; data holds its last value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load <= 1'b0;
      data <= '0;
    end else begin
      load <= fire;
      if (fire) data <= WIDTH'(head.data);
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench: load_sequencer closed-loop with a
// small loadable counter model.
module tb_load_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_data;
  logic       req_imm;
  logic       req_ready;
  logic       flush;
  logic [3:0] q;
  logic       load;
  logic [3:0] data;
  logic [2:0] pending;
  logic       cnt_en;

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  logic       mon_on = 1'b0;
  int         n = 0;
  logic [3:0] ldat [8];
  int         lcyc [8];
  int         b2b = 0;
  logic       prev_load = 1'b0;
  logic [3:0] prevq;

  always #5 clk = ~clk;

  load_sequencer #(
    .WIDTH (4),
    .DEPTH (4),
    .TC    (4'hF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_imm   (req_imm),
    .req_ready (req_ready),
    .flush     (flush),
    .q         (q),
    .load      (load),
    .data      (data),
    .pending   (pending)
  );

  // Loadable counter the sequencer drives.
  always @(posedge clk or negedge rst) begin
    if (!rst)        q <= 4'h0;
    else if (load)   q <= data;
    else if (cnt_en) q <= q + 4'h1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse logger and back-to-back detector.
  always @(negedge clk) begin
    if (mon_on && load) begin
      if (n < 8) begin
        ldat[n] = data;
        lcyc[n] = cyc;
      end
      n++;
    end
    if (rst && load && prev_load) b2b++;
    prev_load = load;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic imm);
    req_valid = 1'b1;
    req_data  = d;
    req_imm   = imm;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_data = 4'h0;
    req_imm = 1'b0;
    flush = 1'b0;
    cnt_en = 1'b0;

    // reset state
    #2;
    chk("rst_load", load, 0);
    chk("rst_data", data, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_ready", req_ready, 1);
    @(negedge clk);

    // immediate entry latency
    push(4'h9, 1'b1);
    chk("t2_pend1", pending, 1);
    chk("t2_noload", load, 0);
    @(negedge clk);
    chk("t2_load", load, 1);
    chk("t2_data", data, 4'h9);
    chk("t2_pend0", pending, 0);
    @(negedge clk);
    chk("t2_load_off", load, 0);
    chk("t2_q", q, 4'h9);

    // terminal-count entry
    push(4'h3, 1'b0);
    cnt_en = 1'b1;
    prevq = q;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load) break;
      prevq = q;
    end
    chk("t3_load", load, 1);
    chk("t3_prevq", prevq, 4'hF);
    chk("t3_data", data, 4'h3);
    @(negedge clk);
    chk("t3_q", q, 4'h3);
    cnt_en = 1'b0;

    // fill to full, reject 5th, drain in order
    for (int i = 0; i < 4; i++) begin
      chk("t4_ready", req_ready, 1);
      case (i)
        0: push(4'h1, 1'b0);
        1: push(4'h2, 1'b0);
        2: push(4'h4, 1'b0);
        default: push(4'h5, 1'b0);
      endcase
    end
    chk("t4_pend4", pending, 4);
    chk("t4_full", req_ready, 0);
    push(4'h7, 1'b1);
    chk("t4_pend_hold", pending, 4);
    n = 0;
    mon_on = 1'b1;
    cnt_en = 1'b1;
    repeat (120) @(negedge clk);
    mon_on = 1'b0;
    cnt_en = 1'b0;
    chk("t4_nloads", n, 4);
    chk("t4_d0", ldat[0], 4'h1);
    chk("t4_d1", ldat[1], 4'h2);
    chk("t4_d2", ldat[2], 4'h4);
    chk("t4_d3", ldat[3], 4'h5);
    chk("t4_pend0", pending, 0);

    // two TC entries with q held at F
    push(4'hF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_qF", q, 4'hF);
    n = 0;
    mon_on = 1'b1;
    push(4'hF, 1'b0);
    push(4'h2, 1'b0);
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    chk("t5_nloads", n, 2);
    chk("t5_d0", ldat[0], 4'hF);
    chk("t5_d1", ldat[1], 4'h2);
    chk("t5_gap", lcyc[1] - lcyc[0], 3);
    chk("t5_q", q, 4'h2);

    // flush with a concurrent push
    push(4'hA, 1'b0);
    push(4'hB, 1'b0);
    push(4'hC, 1'b0);
    chk("t6_pend3", pending, 3);
    flush = 1'b1;
    req_valid = 1'b1;
    req_data = 4'hD;
    req_imm = 1'b1;
    #1 chk("t6_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("t6_pend0", pending, 0);
    n = 0;
    mon_on = 1'b1;
    cnt_en = 1'b1;
    repeat (40) @(negedge clk);
    mon_on = 1'b0;
    cnt_en = 1'b0;
    chk("t6_noloads", n, 0);

    // reset in the middle of a LOAD pulse
    push(4'h5, 1'b1);
    push(4'h6, 1'b0);
    chk("t1_pre_load", load, 1);
    chk("t1_pre_pend", pending, 1);
    rst = 1'b0;
    #1;
    chk("t1_load", load, 0);
    chk("t1_data", data, 0);
    chk("t1_pend", pending, 0);
    chk("t1_ready_rst", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t1_ready", req_ready, 1);
    @(negedge clk);
    chk("t1_noload", load, 0);

    chk("no_b2b", b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
